// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, parity positions and syndrome/correction helpers.
// Latency: none (package only).
// Backpressure: not applicable.
package hamming_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;

  // Parity bits sit at the power-of-two positions of the codeword.
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P4 = 4;

  typedef logic [CW_W:1]   cw_t;
  typedef logic [DATA_W:1] data_t;
  typedef logic [2:0]      syn_t;

  // Decoded result as carried by the output stage.
  typedef struct packed {
    data_t data;
    logic  flag;
    syn_t  pos;
  } dec_t;

  // Each syndrome bit re-checks the parity group whose positions have
  // that power-of-two bit set; the encoder builds p1/p2/p4 from the same
  // groups, so a clean word yields zero.
  function automatic syn_t calc_syndrome(input cw_t cw);
    syn_t s;
    s = '0;
    for (int i = 1; i <= CW_W; i++) begin
      if ((i & P1) != 0) s[0] = s[0] ^ cw[i];
      if ((i & P2) != 0) s[1] = s[1] ^ cw[i];
      if ((i & P4) != 0) s[2] = s[2] ^ cw[i];
    end
    return s;
  endfunction

  // Invert the bit the syndrome points at; a zero syndrome leaves the word alone.
  function automatic cw_t correct_cw(input cw_t cw, input syn_t s);
    cw_t c;
    c = cw;
    for (int i = 1; i <= CW_W; i++) begin
      if (s == i[2:0]) c[i] = ~c[i];
    end
    return c;
  endfunction

  // Data bits live at the non-parity positions 3, 5, 6, 7.
  function automatic data_t extract_data(input cw_t cw);
    return {cw[7], cw[6], cw[5], cw[3]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming(7,4) check: syndrome of a codeword and its single-error-corrected data.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_W:1]   cw,
  output logic [2:0]      syn,
  output logic [DATA_W:1] data
);

  // Syndrome and corrected data derived straight from the codeword.
  always_comb begin
    syn  = calc_syndrome(cw);
    data = extract_data(correct_cw(cw, calc_syndrome(cw)));
  end

endmodule

// File: rtl/hamming_decoder.sv
// Hamming(7,4) decoder: syndrome in stage 1, correction + registered outputs in stage 2, saturating error counter.
// Latency: 2 cycles from input handshake to dec_valid; 1 word per cycle throughput.
// Backpressure: outputs hold while dec_valid && !dec_ready; cw_ready drops once stage 1 is also full.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_dec,
  input  logic             rst_dec_n,
  input  logic [CW_W:1]    codeword_in,
  input  logic             cw_valid,
  output logic             cw_ready,
  output logic [DATA_W:1]  dec_data,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic             err_flag,
  output logic [2:0]       err_pos,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Stage 1 state.
  logic            s1_valid;
  logic [CW_W:1]   s1_cw;
  logic [2:0]      s1_syn;

  // Handshake / pipeline control.
  logic            in_fire;
  logic            out_fire;
  logic            s2_load;

  // Syndrome of the incoming word; the corrected data from this instance
  // is not needed because correction happens one stage later.
  logic [2:0]      in_syn;
  logic [DATA_W:1] unused_in_data;

  // Next contents of the output stage, built from the stage-1 word.
  dec_t            s2_next;

  hamming_syndrome u_syndrome (
    .cw   (codeword_in),
    .syn  (in_syn),
    .data (unused_in_data)
  );

  // Stage 2 may take a new word when it is empty or its word leaves this
  // cycle; stage 1 can accept when empty or when it drains into stage 2.
  always_comb begin
    s2_load  = !dec_valid || dec_ready;
    cw_ready = !s1_valid || s2_load;
    in_fire  = cw_valid && cw_ready;
    out_fire = dec_valid && dec_ready;
  end

  // Correction of the stage-1 word using the syndrome captured with it.
  always_comb begin
    s2_next      = '0;
    s2_next.data = extract_data(correct_cw(s1_cw, s1_syn));
    s2_next.flag = |s1_syn;
    s2_next.pos  = s1_syn;
  end

  // Stage 1: capture codeword and syndrome on input handshake.
  always_ff @(posedge clk_dec or negedge rst_dec_n) begin
    if (!rst_dec_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_cw    <= codeword_in;
        s1_syn   <= in_syn;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: register corrected result; hold everything while stalled.
  always_ff @(posedge clk_dec or negedge rst_dec_n) begin
    if (!rst_dec_n) begin
      dec_valid <= 1'b0;
      dec_data  <= '0;
      err_flag  <= 1'b0;
      err_pos   <= '0;
    end else if (s2_load) begin
      dec_valid <= s1_valid;
      if (s1_valid) begin
        dec_data <= s2_next.data;
        err_flag <= s2_next.flag;
        err_pos  <= s2_next.pos;
      end
    end
  end

  // Count corrected words as they are delivered; clear wins over increment.
  always_ff @(posedge clk_dec or negedge rst_dec_n) begin
    if (!rst_dec_n) begin
      err_count <= '0;
    end else if (cnt_clr) begin
      err_count <= '0;
    end else if (out_fire && err_flag && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_ONE;
    end
  end

endmodule
